// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types, defaults and init pattern for the data memory
// FSM state type, CPU-level default geometry and the power-up test pattern.
package data_memory_pkg;

  localparam int DMEM_DATA_W    = 8;
  localparam int DMEM_ADDR_W    = 8;
  localparam int DMEM_DEPTH     = 256;
  localparam int DMEM_INIT_HALF = 16;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } dmem_state_e;

  // Lower half counts up from 0, upper half counts down from -1, the rest is 0.
  function automatic logic [63:0] init_word(input int unsigned index,
                                            input int unsigned half,
                                            input int unsigned dw);
    logic [63:0] w;
    logic [63:0] mask;
    if (index < half) begin
      w = 64'(index);
    end else if (index < 2 * half) begin
      w = 64'd0 - 64'(index - half + 1);
    end else begin
      w = '0;
    end
    mask = (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    return w & mask;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - word storage with one write port and a registered read port
// Reads return the pre-write contents when both ports hit the same word on one edge.
module data_memory_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_param.sv
// rtl/data_memory_param.sv - parametrised data memory with init sequencer and handshake
// Holds the init FSM, request acceptance, range check and sticky error flag.
module data_memory_param
  import data_memory_pkg::*;
#(
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DEPTH     = DMEM_DEPTH,
  parameter int INIT_HALF = DMEM_INIT_HALF
) (
  input  logic              input_clk,
  input  logic              input_reset_n,
  input  logic              input_Valid,
  output logic              output_Ready,
  input  logic              input_Memread,
  input  logic              input_Memwrite,
  input  logic [ADDR_W-1:0] input_Address,
  input  logic [DATA_W-1:0] input_Writedata,
  output logic [DATA_W-1:0] output_Readdata,
  output logic              output_Readvalid,
  output logic              output_Busy,
  output logic              output_Error,
  input  logic              input_Clearerr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             rvalid_q, rvalid_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;

  logic              accept;
  logic              oor;
  logic              err_set;
  logic              arr_we;
  logic              arr_re;
  logic [IDX_W-1:0]  arr_waddr;
  logic [IDX_W-1:0]  req_idx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign accept  = input_Valid && ready_q;
  assign oor     = 32'(input_Address) >= DEPTH;
  assign req_idx = IDX_W'(input_Address);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    rvalid_d  = 1'b0;
    zero_d    = zero_q;
    err_set   = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = req_idx;
    arr_wdata = input_Writedata;

    if (state_q == ST_INIT) begin
      arr_we    = 1'b1;
      arr_waddr = IDX_W'(cnt_q);
      arr_wdata = DATA_W'(init_word(32'(cnt_q), INIT_HALF, DATA_W));
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DEPTH - 1)) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end else if (accept) begin
      arr_we   = input_Memwrite && !oor;
      arr_re   = input_Memread && !oor;
      rvalid_d = input_Memread;
      if (input_Memread) begin
        zero_d = oor;
      end
      err_set = oor && (input_Memread || input_Memwrite);
    end

    // A new out-of-range hit wins over a clear on the same edge.
    if (err_set) begin
      err_d = 1'b1;
    end else if (input_Clearerr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge input_clk or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
    end
  end

  data_memory_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (input_clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_idx),
    .rdata (arr_rdata)
  );

  // Array read data is not resettable, so reset and out-of-range reads mask it to zero.
  assign output_Readdata  = zero_q ? '0 : arr_rdata;
  assign output_Readvalid = rvalid_q;
  assign output_Busy      = busy_q;
  assign output_Ready     = ready_q;
  assign output_Error     = err_q;

endmodule

// File: tb/tb_data_memory_param.sv
// tb/tb_data_memory_param.sv - directed self-checking bench for data_memory_param
// Instance a uses default geometry; instance b has DEPTH=64 for range checks.
module tb_data_memory_param;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  logic       a_valid = 0, a_rd = 0, a_wr = 0, a_clr = 0;
  logic [7:0] a_addr = 0, a_wdata = 0;
  logic       a_ready, a_rv, a_busy, a_err;
  logic [7:0] a_rdata;

  logic       b_valid = 0, b_rd = 0, b_wr = 0, b_clr = 0;
  logic [7:0] b_addr = 0, b_wdata = 0;
  logic       b_ready, b_rv, b_busy, b_err;
  logic [7:0] b_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_param u_dut_a (
    .input_clk        (clk),
    .input_reset_n    (rst_n_a),
    .input_Valid      (a_valid),
    .output_Ready     (a_ready),
    .input_Memread    (a_rd),
    .input_Memwrite   (a_wr),
    .input_Address    (a_addr),
    .input_Writedata  (a_wdata),
    .output_Readdata  (a_rdata),
    .output_Readvalid (a_rv),
    .output_Busy      (a_busy),
    .output_Error     (a_err),
    .input_Clearerr   (a_clr)
  );

  data_memory_param #(
    .DATA_W (8), .ADDR_W (8), .DEPTH (64), .INIT_HALF (16)
  ) u_dut_b (
    .input_clk        (clk),
    .input_reset_n    (rst_n_b),
    .input_Valid      (b_valid),
    .output_Ready     (b_ready),
    .input_Memread    (b_rd),
    .input_Memwrite   (b_wr),
    .input_Address    (b_addr),
    .input_Writedata  (b_wdata),
    .output_Readdata  (b_rdata),
    .output_Readvalid (b_rv),
    .output_Busy      (b_busy),
    .output_Error     (b_err),
    .input_Clearerr   (b_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request presented for a single edge; returns #1 after that edge.
  task automatic req(input bit on_b, input bit rd, input bit wr,
                     input logic [7:0] addr, input logic [7:0] data, input bit clr);
    @(negedge clk);
    if (!on_b) begin
      a_valid = 1; a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = data; a_clr = clr;
    end else begin
      b_valid = 1; b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = data; b_clr = clr;
    end
    @(posedge clk);
    #1;
    a_valid = 0; a_rd = 0; a_wr = 0; a_clr = 0;
    b_valid = 0; b_rd = 0; b_wr = 0; b_clr = 0;
  endtask

  // Counts edges after release until Busy drops; optionally pokes a request at cycle 10.
  task automatic count_init(input bit inject, output int n, output bit rv_seen);
    n = 0;
    rv_seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (a_rv) rv_seen = 1;
      if (inject && n == 10) begin
        a_valid = 1; a_rd = 1; a_wr = 1; a_addr = 8'd5; a_wdata = 8'h99;
      end
      if (n == 11) begin
        a_valid = 0; a_rd = 0; a_wr = 0;
      end
      if (!a_busy) break;
    end
  endtask

  task automatic read_a(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    req(0, 1, 0, addr, 8'h00, 0);
    check({tag, "_rv"}, a_rv, 1'b1);
    check(tag, a_rdata, exp);
  endtask

  initial begin
    int  n;
    bit  rv_seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 1'b1);
    check("rst_ready", a_ready, 1'b0);
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_rv", a_rv, 1'b0);
    check("rst_err", a_err, 1'b0);

    @(negedge clk);
    rst_n_a = 1; rst_n_b = 1;
    repeat (100) @(posedge clk);
    #1;
    check("midinit_busy", a_busy, 1'b1);
    @(negedge clk);
    rst_n_a = 0;
    #1;
    check("midinit_rst_busy", a_busy, 1'b1);
    @(negedge clk);
    rst_n_a = 1;

    count_init(1, n, rv_seen);
    check("init_cycles", n, 256);
    check("init_no_rv", rv_seen, 1'b0);
    check("ready_after_init", a_ready, 1'b1);
    check("busy_after_init", a_busy, 1'b0);

    read_a("rd5", 8'd5, 8'h05);
    read_a("rd16", 8'd16, 8'hFF);
    read_a("rd31", 8'd31, 8'hF0);
    read_a("rd32", 8'd32, 8'h00);
    read_a("rd10", 8'd10, 8'h0A);
    read_a("rd255", 8'd255, 8'h00);

    req(0, 0, 1, 8'd40, 8'hA5, 0);
    check("wr40_no_rv", a_rv, 1'b0);
    read_a("rd40", 8'd40, 8'hA5);
    @(posedge clk);
    #1;
    check("rd40_rv_drop", a_rv, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rd40_hold", a_rdata, 8'hA5);

    req(0, 1, 1, 8'd3, 8'h7E, 0);
    check("swap_rv", a_rv, 1'b1);
    check("swap_old", a_rdata, 8'h03);
    read_a("rd3_new", 8'd3, 8'h7E);

    req(0, 0, 0, 8'd3, 8'h00, 0);
    check("noop_rv", a_rv, 1'b0);
    check("noop_hold", a_rdata, 8'h7E);

    req(0, 0, 1, 8'd2, 8'h55, 0);
    read_a("rd2_new", 8'd2, 8'h55);
    rst_n_a = 0;
    #1;
    check("rst2_rv", a_rv, 1'b0);
    check("rst2_rdata", a_rdata, 8'h00);
    check("rst2_busy", a_busy, 1'b1);
    check("rst2_ready", a_ready, 1'b0);
    @(negedge clk);
    rst_n_a = 1;
    count_init(0, n, rv_seen);
    check("reinit_cycles", n, 256);
    read_a("rd2_reinit", 8'd2, 8'h02);

    check("b_ready", b_ready, 1'b1);
    check("b_err0", b_err, 1'b0);
    req(1, 1, 0, 8'd20, 8'h00, 0);
    check("b_rd20", b_rdata, 8'hFB);
    req(1, 0, 1, 8'd100, 8'h11, 0);
    check("b_oorw_err", b_err, 1'b1);
    check("b_oorw_rv", b_rv, 1'b0);
    req(1, 1, 0, 8'd100, 8'h00, 0);
    check("b_oorr_rv", b_rv, 1'b1);
    check("b_oorr_data", b_rdata, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check("b_err_sticky", b_err, 1'b1);
    req(1, 0, 0, 8'd0, 8'h00, 1);
    check("b_err_clr", b_err, 1'b0);
    req(1, 1, 0, 8'd36, 8'h00, 0);
    check("b_rd36_rv", b_rv, 1'b1);
    check("b_rd36", b_rdata, 8'h00);
    check("b_inrange_noerr", b_err, 1'b0);
    req(1, 1, 0, 8'd64, 8'h00, 1);
    check("b_set_over_clr", b_err, 1'b1);
    req(1, 1, 0, 8'd63, 8'h00, 0);
    check("b_rd63", b_rdata, 8'h00);
    check("b_rd63_rv", b_rv, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
